mux_nx1_stream: RTL and testbench

//  Parametrised NUM_IN:1 streaming route mux for CGRA PE/switch inputs. Select is a

---
 rtl/mux_nx1_stream_if.sv | 37 +++
 rtl/mux_nx1_stream.sv | 147 ++++++++++++++
 tb/tb_mux_nx1_stream.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_nx1_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_nx1_stream_if
// Description : Handshake bundle for the NUM_IN:1 streaming route mux:
//               packed input channels, select configuration port and the
//               registered output stream. "slave" is the mux side,
//               "master" is the side that feeds and drains it.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_nx1_stream_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 16
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    cfg_we;
    logic [SEL_W-1:0]        cfg_sel;
    logic                    cfg_ready;
    logic                    cfg_err;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, cfg_we, cfg_sel, out_ready,
        input  in_ready, cfg_ready, cfg_err, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, cfg_we, cfg_sel, out_ready,
        output in_ready, cfg_ready, cfg_err, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_nx1_stream.sv
`default_nettype none
// ============================================================================
// Module      : mux_nx1_stream
// Description : Parametrised NUM_IN:1 streaming route mux for CGRA PE/switch
//               inputs. The select is a configuration register that may only
//               change while the pipe is empty; the output is a registered
//               2-entry skid buffer with valid/ready handshake.
//               Optional feature macro: MUX_CNT_EN adds a 16-bit pop counter
//               (xfer_cnt) with synchronous clear (cnt_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nx1_stream #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mux_nx1_stream_if.slave     bus
`ifdef MUX_CNT_EN
    ,
    output logic [15:0]         xfer_cnt,
    input  wire logic           cnt_clr
`endif
);
    localparam int SEL_W = $clog2(NUM_IN);

    // Buffer occupancy encoding (entries held in the skid buffer)
    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    logic [SEL_W-1:0]  r_sel;
    logic              r_cfg_err;
    logic [1:0]        r_occ;
    logic [WIDTH-1:0]  r_head;
    logic [WIDTH-1:0]  r_tail;

    logic [WIDTH-1:0]  w_sel_data;
    logic              w_sel_valid;
    logic              w_room;
    logic              w_push;
    logic              w_pop;
    logic              w_cfg_acc;
    logic              w_sel_ok;
    logic [NUM_IN-1:0] w_in_ready;

    // Route the configured channel's data and valid towards the buffer
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_data  = bus.in_data[i*WIDTH +: WIDTH];
                w_sel_valid = bus.in_valid[i];
            end
        end
    end

    // A config write stalls the input so a select change never races a push
    assign w_room    = (r_occ != c_OCC_FULL);
    assign w_push    = w_sel_valid & w_room & ~bus.cfg_we;
    assign w_pop     = (r_occ != c_OCC_EMPTY) & bus.out_ready;
    assign w_cfg_acc = bus.cfg_we & (r_occ == c_OCC_EMPTY);
    assign w_sel_ok  = (int'(bus.cfg_sel) < NUM_IN);

    generate
        for (genvar g = 0; g < NUM_IN; g++) begin : g_ready
            assign w_in_ready[g] = (r_sel == SEL_W'(g)) & w_room & ~bus.cfg_we;
        end
    endgenerate

    // Select register and sticky out-of-range error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= '0;
            r_cfg_err <= 1'b0;
        end else if (w_cfg_acc) begin
            if (w_sel_ok) begin
                r_sel <= bus.cfg_sel;
            end else begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    // Two-entry skid buffer; r_head is always the word presented downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= c_OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_occ)
                c_OCC_EMPTY: begin
                    if (w_push) begin
                        r_head <= w_sel_data;
                        r_occ  <= c_OCC_ONE;
                    end
                end
                c_OCC_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= w_sel_data;
                    end else if (w_push) begin
                        r_tail <= w_sel_data;
                        r_occ  <= c_OCC_FULL;
                    end else if (w_pop) begin
                        r_occ  <= c_OCC_EMPTY;
                    end
                end
                default: begin
                    // Full: no push possible, a pop promotes the tail
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_occ  <= c_OCC_ONE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.cfg_ready = (r_occ == c_OCC_EMPTY);
    assign bus.cfg_err   = r_cfg_err;
    assign bus.out_data  = r_head;
    assign bus.out_valid = (r_occ != c_OCC_EMPTY);

`ifdef MUX_CNT_EN
    logic [15:0] r_xfer_cnt;

    // Count output pops; clear takes priority over a same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (cnt_clr) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`else
    // No transfer counter in this build
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nx1_stream
// Description : Self-checking bench for mux_nx1_stream. Instance A (16x16)
//               is checked every cycle against a queue-based model; B (4x8)
//               streams through a scoreboard with random back-pressure;
//               C (5x8) exercises out-of-range select writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nx1_stream;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    mux_nx1_stream_if #(.WIDTH(16), .NUM_IN(16)) a_if ();
    mux_nx1_stream_if #(.WIDTH(8),  .NUM_IN(4))  b_if ();
    mux_nx1_stream_if #(.WIDTH(8),  .NUM_IN(5))  c_if ();

`ifdef MUX_CNT_EN
    logic [15:0] a_cnt, b_cnt, c_cnt;
    logic        a_cnt_clr = 1'b0;
    logic        b_cnt_clr = 1'b0;
    logic        c_cnt_clr = 1'b0;
`endif

    mux_nx1_stream #(.WIDTH(16), .NUM_IN(16)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
`ifdef MUX_CNT_EN
        , .xfer_cnt(a_cnt), .cnt_clr(a_cnt_clr)
`endif
    );
    mux_nx1_stream #(.WIDTH(8), .NUM_IN(4)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
`ifdef MUX_CNT_EN
        , .xfer_cnt(b_cnt), .cnt_clr(b_cnt_clr)
`endif
    );
    mux_nx1_stream #(.WIDTH(8), .NUM_IN(5)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(c_if)
`ifdef MUX_CNT_EN
        , .xfer_cnt(c_cnt), .cnt_clr(c_cnt_clr)
`endif
    );

    // Reference model state for instance A
    logic [15:0] q_a[$];
    logic [3:0]  m_sel;
    logic        m_err;
    logic [15:0] m_head;
    logic [15:0] m_cnt;
    int          m_pops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] dat_a(input int ch, input logic [15:0] w);
        logic [255:0] r;
        r = {8{32'hBAD0_BAD1}};
        r[ch*16 +: 16] = w;
        return r;
    endfunction

    // One clock of instance A: drive, compare with model, advance model
    task automatic step_a(input logic [255:0] d, input logic [15:0] v, input logic we,
                          input logic [3:0] cs, input logic ordy);
        logic [15:0] exp_rdy;
        logic        pop;
        logic        push;
        logic [15:0] word;
        a_if.in_data   = d;
        a_if.in_valid  = v;
        a_if.cfg_we    = we;
        a_if.cfg_sel   = cs;
        a_if.out_ready = ordy;
        #1;
        exp_rdy = '0;
        if (q_a.size() < 2 && !we) exp_rdy[m_sel] = 1'b1;
        chk("a_out_valid", 32'(a_if.out_valid), 32'(q_a.size() != 0));
        chk("a_out_data",  32'(a_if.out_data),  32'((q_a.size() != 0) ? q_a[0] : m_head));
        chk("a_cfg_ready", 32'(a_if.cfg_ready), 32'(q_a.size() == 0));
        chk("a_in_ready",  32'(a_if.in_ready),  32'(exp_rdy));
        chk("a_cfg_err",   32'(a_if.cfg_err),   32'(m_err));
`ifdef MUX_CNT_EN
        chk("a_xfer_cnt",  32'(a_cnt),          32'(m_cnt));
`endif
        pop  = (q_a.size() != 0) && ordy;
        push = v[m_sel] && (q_a.size() < 2) && !we;
        word = d[m_sel*16 +: 16];
        if (we && q_a.size() == 0) begin
            if (int'(cs) < 16) m_sel = cs;
            else m_err = 1'b1;
        end
        if (pop) begin
            void'(q_a.pop_front());
            m_pops++;
        end
        if (push) q_a.push_back(word);
        if (q_a.size() != 0) m_head = q_a[0];
`ifdef MUX_CNT_EN
        if (a_cnt_clr) m_cnt = 16'd0;
        else if (pop) m_cnt = m_cnt + 16'd1;
`endif
        @(posedge clk);
        #1;
    endtask

    // Hard stop if something stalls the sequence
    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b_src[$];
        logic [7:0]  b_exp[$];
        logic [7:0]  b_rcv[$];
        logic        b_acc;
        logic [255:0] rd;

        rst_n = 1'b0;
        a_if.in_data = '0; a_if.in_valid = '0; a_if.cfg_we = 1'b0; a_if.cfg_sel = '0; a_if.out_ready = 1'b0;
        b_if.in_data = '0; b_if.in_valid = '0; b_if.cfg_we = 1'b0; b_if.cfg_sel = '0; b_if.out_ready = 1'b0;
        c_if.in_data = '0; c_if.in_valid = '0; c_if.cfg_we = 1'b0; c_if.cfg_sel = '0; c_if.out_ready = 1'b0;
        q_a.delete(); m_sel = '0; m_err = 1'b0; m_head = '0; m_cnt = '0; m_pops = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst_out_data",  32'(a_if.out_data),  32'd0);
        chk("rst_cfg_ready", 32'(a_if.cfg_ready), 32'd1);
        chk("rst_cfg_err",   32'(a_if.cfg_err),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Route ch5, four back-to-back words with all other channels valid
        step_a('0, 16'h0000, 1'b1, 4'd5, 1'b1);
        for (int k = 1; k <= 4; k++) step_a(dat_a(5, 16'(k)), 16'hFFFF, 1'b0, 4'd0, 1'b1);
        repeat (2) step_a(dat_a(5, 16'h0), 16'hFFDF, 1'b0, 4'd0, 1'b1);

        // Back-pressure: fill to two, third waits for the first pop
        step_a('0, 16'h0000, 1'b1, 4'd3, 1'b0);
        step_a(dat_a(3, 16'h0031), 16'h0008, 1'b0, 4'd0, 1'b0);
        step_a(dat_a(3, 16'h0032), 16'h0008, 1'b0, 4'd0, 1'b0);
        step_a(dat_a(3, 16'h0033), 16'h0008, 1'b0, 4'd0, 1'b0);
        step_a(dat_a(3, 16'h0033), 16'h0008, 1'b0, 4'd0, 1'b1);
        step_a(dat_a(3, 16'h0033), 16'h0008, 1'b0, 4'd0, 1'b1);
        repeat (3) step_a('0, 16'h0000, 1'b0, 4'd0, 1'b1);

        // Config write with a word in flight is ignored; retried when drained
        step_a(dat_a(3, 16'h0041), 16'h0008, 1'b0, 4'd0, 1'b0);
        step_a('0, 16'h0000, 1'b1, 4'd7, 1'b0);
        step_a('0, 16'h0000, 1'b0, 4'd0, 1'b1);
        step_a('0, 16'h0000, 1'b1, 4'd7, 1'b0);
        step_a(dat_a(7, 16'h0077), 16'hFFFF, 1'b0, 4'd0, 1'b1);
        step_a('0, 16'h0000, 1'b0, 4'd0, 1'b1);

        // Out-of-range select (NUM_IN=5 so that 5..7 are encodable)
        c_if.cfg_we = 1'b1; c_if.cfg_sel = 3'd4;
        @(posedge clk); #1;
        c_if.cfg_we = 1'b0;
        c_if.in_valid = 5'b11111;
        c_if.in_data = {8'hC4, 8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        chk("c_err_after_good", 32'(c_if.cfg_err),  32'd0);
        chk("c_ready_sel4",     32'(c_if.in_ready), 32'h10);
        @(posedge clk); #1;
        c_if.in_valid = '0;
        c_if.out_ready = 1'b1;
        chk("c_out_valid", 32'(c_if.out_valid), 32'd1);
        chk("c_out_data",  32'(c_if.out_data),  32'hC4);
        @(posedge clk); #1;
        c_if.cfg_we = 1'b1; c_if.cfg_sel = 3'd5;
        #1;
        chk("c_cfg_ready_empty", 32'(c_if.cfg_ready), 32'd1);
        @(posedge clk); #1;
        c_if.cfg_we = 1'b0;
        #1;
        chk("c_err_set",      32'(c_if.cfg_err),  32'd1);
        chk("c_sel_kept",     32'(c_if.in_ready), 32'h10);
        c_if.cfg_we = 1'b1; c_if.cfg_sel = 3'd0;
        @(posedge clk); #1;
        c_if.cfg_we = 1'b0;
        #1;
        chk("c_err_sticky",   32'(c_if.cfg_err),  32'd1);
        chk("c_sel_good_now", 32'(c_if.in_ready), 32'h01);

        // NUM_IN=4, WIDTH=8 stream on ch2 with random out_ready
        b_src.push_back(8'hA5);
        b_src.push_back(8'h5A);
        for (int k = 0; k < 20; k++) b_src.push_back(8'($urandom()));
        b_exp = b_src;
        b_if.cfg_we = 1'b1; b_if.cfg_sel = 2'd2;
        @(posedge clk); #1;
        b_if.cfg_we = 1'b0;
        for (int cyc = 0; cyc < 400 && b_rcv.size() < b_exp.size(); cyc++) begin
            b_if.in_valid  = (b_src.size() != 0) ? 4'b1111 : 4'b1011;
            b_if.in_data   = {8'h33, (b_src.size() != 0) ? b_src[0] : 8'h00, 8'h11, 8'h00};
            b_if.out_ready = 1'($urandom_range(0, 1));
            #1;
            b_acc = b_if.in_valid[2] && b_if.in_ready[2];
            if ((b_if.in_ready & 4'b1011) != 4'b0000) chk("b_unsel_ready", 32'(b_if.in_ready), 32'h4);
            if (b_if.out_valid && b_if.out_ready) b_rcv.push_back(b_if.out_data);
            @(posedge clk); #1;
            if (b_acc) void'(b_src.pop_front());
        end
        b_if.in_valid = '0;
        chk("b_word_count", 32'(b_rcv.size()), 32'(b_exp.size()));
        for (int k = 0; k < b_exp.size() && k < b_rcv.size(); k++)
            chk("b_word", 32'(b_rcv[k]), 32'(b_exp[k]));

        // Randomized traffic on A against the model
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom();
            step_a(rd, 16'($urandom()), ($urandom_range(0, 7) == 0), 4'($urandom()),
                   ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset with a full buffer
        repeat (2) step_a('0, 16'h0000, 1'b0, 4'd0, 1'b1);
        step_a(dat_a(int'(m_sel), 16'hF001), 16'hFFFF, 1'b0, 4'd0, 1'b0);
        step_a(dat_a(int'(m_sel), 16'hF002), 16'hFFFF, 1'b0, 4'd0, 1'b0);
        chk("t5_full_cfg_ready", 32'(a_if.cfg_ready), 32'd0);
        a_if.cfg_we = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("t5_rst_out_data",  32'(a_if.out_data),  32'd0);
        chk("t5_rst_cfg_ready", 32'(a_if.cfg_ready), 32'd1);
        chk("t5_rst_cfg_err",   32'(a_if.cfg_err),   32'd0);
        chk("t5_rst_sel0",      32'(a_if.in_ready),  32'h0001);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q_a.delete(); m_sel = '0; m_err = 1'b0; m_head = '0; m_cnt = '0; m_pops = 0;
        step_a(dat_a(0, 16'h5A5A), 16'hFFFF, 1'b0, 4'd0, 1'b1);
        step_a('0, 16'h0000, 1'b0, 4'd0, 1'b1);

`ifdef MUX_CNT_EN
        // Counter wrap over 0x10002 pops, then clear beats a same-cycle pop
        for (int n = 0; n < 32'h10010 && m_pops < 32'h10002; n++)
            step_a(dat_a(0, 16'(n)), 16'h0001, 1'b0, 4'd0, 1'b1);
        chk("t6_pops_done", 32'(m_pops), 32'h10002);
        chk("t6_cnt_wrap",  32'(a_cnt),  32'h0002);
        a_cnt_clr = 1'b1;
        step_a(dat_a(0, 16'h0BEE), 16'h0001, 1'b0, 4'd0, 1'b1);
        a_cnt_clr = 1'b0;
        chk("t6_clr_wins",  32'(a_cnt),  32'h0000);
        step_a('0, 16'h0000, 1'b0, 4'd0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
